// File: rtl/vx_dcache_arb_pkg.sv
// Shared types and sizing helpers for the lane-aware D$ port arbiter.
package vx_dcache_arb_pkg;

  typedef enum logic [1:0] {
    ARB_HOLD    = 2'd0,
    ARB_LOCK    = 2'd1,
    ARB_RELEASE = 2'd2,
    ARB_ABORT   = 2'd3
  } arb_upd_e;

  function automatic int log2up(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Tag width seen by the cache once the requester index is appended.
  function automatic int tag_out_width(input int tag_in_width, input int num_reqs);
    return tag_in_width + ((num_reqs > 32'sd1) ? log2up(num_reqs) : 32'sd0);
  endfunction

endpackage

// File: rtl/vx_dcache_arb_chk.sv
// Protocol checks for the D$ arbiter: a lock holder must keep lanes valid and
// every response must carry an in-range requester index.
module vx_dcache_arb_chk #(
  parameter int NUM_REQS = 2,
  parameter int SELW     = 1
) (
  input logic                clk,
  input logic                reset,
  input logic                locked,
  input logic [SELW-1:0]     lock_idx,
  input logic [NUM_REQS-1:0] pending,
  input logic                rsp_valid,
  input logic [SELW-1:0]     rsp_idx
);

  localparam int            CW    = SELW + 1;
  localparam logic [SELW:0] NUM_W = CW'(NUM_REQS);

  a_lock_drop: assert property (@(posedge clk) disable iff (reset) locked |-> pending[lock_idx])
    else $warning("vx_dcache_arb: locked requester %0d dropped all lanes", lock_idx);

  a_rsp_idx: assert property (@(posedge clk) disable iff (reset) rsp_valid |-> ({1'b0, rsp_idx} < NUM_W))
    else $error("vx_dcache_arb: response index %0d out of range", rsp_idx);

endmodule

// File: rtl/vx_dcache_arb_rr.sv
// Round-robin requester arbiter whose grant stays pinned to one requester
// until that requester's multi-lane request has fully drained.
module vx_dcache_arb_rr
  import vx_dcache_arb_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int SELW     = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] pending,
  input  logic                done,
  output logic                grant_valid,
  output logic [SELW-1:0]     grant_idx,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic                locked,
  output logic [SELW-1:0]     lock_idx
);

  localparam int              CW    = SELW + 1;
  localparam logic [SELW:0]   NUM_W = CW'(NUM_REQS);
  localparam logic [SELW-1:0] LAST  = SELW'(NUM_REQS - 1);

  logic            locked_r;
  logic [SELW-1:0] lock_idx_r;
  logic [SELW-1:0] rr_ptr_r;
  logic            grant_valid_s;
  logic [SELW-1:0] grant_idx_s;
  arb_upd_e        upd_s;

  // Grant search: an active lock wins, otherwise first pending from rr_ptr with wrap.
  always_comb begin
    logic [SELW:0]   cand_v;
    logic [SELW-1:0] sel_v;
    logic            hit_v;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cand_v        = '0;
    sel_v         = '0;
    hit_v         = 1'b0;
    if (locked_r) begin
      grant_valid_s = 1'b1;
      grant_idx_s   = lock_idx_r;
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        cand_v        = {1'b0, rr_ptr_r} + CW'(k);
        sel_v         = (cand_v >= NUM_W) ? SELW'(cand_v - NUM_W) : cand_v[SELW-1:0];
        hit_v         = !grant_valid_s && pending[sel_v];
        grant_idx_s   = hit_v ? sel_v : grant_idx_s;
        grant_valid_s = grant_valid_s | hit_v;
      end
    end
  end

  // Decide how this cycle moves the lock and the round-robin pointer.
  always_comb begin
    upd_s = ARB_HOLD;
    if (locked_r && !pending[lock_idx_r]) begin
      upd_s = ARB_ABORT;
    end else if (grant_valid_s && !done) begin
      upd_s = ARB_LOCK;
    end else if (grant_valid_s) begin
      upd_s = ARB_RELEASE;
    end else begin
      upd_s = ARB_HOLD;
    end
  end

  // Lock, lock owner and round-robin pointer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_r   <= 1'b0;
      lock_idx_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      case (upd_s)
        ARB_LOCK: begin
          locked_r   <= 1'b1;
          lock_idx_r <= grant_idx_s;
        end
        ARB_RELEASE: begin
          locked_r <= 1'b0;
          rr_ptr_r <= (grant_idx_s == LAST) ? '0 : grant_idx_s + 1'b1;
        end
        ARB_ABORT: locked_r <= 1'b0;
        default:   locked_r <= locked_r;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_onehot
    assign grant_onehot[r] = grant_valid_s && (grant_idx_s == SELW'(r));
  end

  assign grant_valid = grant_valid_s;
  assign grant_idx   = grant_idx_s;
  assign locked      = locked_r;
  assign lock_idx    = lock_idx_r;

endmodule

// File: rtl/vx_dcache_arb.sv
// Shares one per-thread D$ port between NUM_REQS requesters; requester index
// rides in the tag LSBs so responses can be steered back.
module vx_dcache_arb
  import vx_dcache_arb_pkg::*;
#(
  parameter int NUM_REQS      = 2,
  parameter int LANES         = 4,
  parameter int ADDRW         = 30,
  parameter int DATAW         = 32,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int REQ_SELW      = log2up(NUM_REQS),
  parameter int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS)
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_REQS-1:0][LANES-1:0]                  in_req_valid,
  input  logic [NUM_REQS-1:0][LANES-1:0]                  in_req_rw,
  input  logic [NUM_REQS-1:0][LANES-1:0][ADDRW-1:0]       in_req_addr,
  input  logic [NUM_REQS-1:0][LANES-1:0][DATAW/8-1:0]     in_req_byteen,
  input  logic [NUM_REQS-1:0][LANES-1:0][DATAW-1:0]       in_req_data,
  input  logic [NUM_REQS-1:0][LANES-1:0][TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0][LANES-1:0]                  in_req_ready,
  output logic [LANES-1:0]                                out_req_valid,
  output logic [LANES-1:0]                                out_req_rw,
  output logic [LANES-1:0][ADDRW-1:0]                     out_req_addr,
  output logic [LANES-1:0][DATAW/8-1:0]                   out_req_byteen,
  output logic [LANES-1:0][DATAW-1:0]                     out_req_data,
  output logic [LANES-1:0][TAG_OUT_WIDTH-1:0]             out_req_tag,
  input  logic [LANES-1:0]                                out_req_ready,
  input  logic                                            out_rsp_valid,
  input  logic [LANES-1:0]                                out_rsp_tmask,
  input  logic [LANES-1:0][DATAW-1:0]                     out_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]                        out_rsp_tag,
  output logic                                            out_rsp_ready,
  output logic [NUM_REQS-1:0]                             in_rsp_valid,
  output logic [NUM_REQS-1:0][LANES-1:0]                  in_rsp_tmask,
  output logic [NUM_REQS-1:0][LANES-1:0][DATAW-1:0]       in_rsp_data,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]           in_rsp_tag,
  input  logic [NUM_REQS-1:0]                             in_rsp_ready
);

  localparam int                CW      = REQ_SELW + 1;
  localparam int                RSP_PAD = 1 << REQ_SELW;
  localparam logic [REQ_SELW:0] NUM_W   = CW'(NUM_REQS);

  logic [NUM_REQS-1:0]                    pending_s;
  logic                                   grant_valid_s;
  logic [REQ_SELW-1:0]                    grant_idx_s;
  logic [NUM_REQS-1:0]                    grant_onehot_s;
  logic                                   done_s;
  logic [LANES-1:0][TAG_OUT_WIDTH-1:0]    req_tag_s;
  logic [REQ_SELW-1:0]                    rsp_idx_s;
  logic [TAG_IN_WIDTH-1:0]                rsp_tag_s;
  logic                                   rsp_ok_s;
  logic [RSP_PAD-1:0]                     rsp_ready_pad_s;

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_pending
    assign pending_s[r] = |in_req_valid[r];
  end

  // Complete once every lane the granted requester still shows fires this cycle.
  assign done_s          = ~|(in_req_valid[grant_idx_s] & ~out_req_ready);
  assign rsp_ok_s        = ({1'b0, rsp_idx_s} < NUM_W);
  assign rsp_ready_pad_s = RSP_PAD'(in_rsp_ready);

  if (NUM_REQS > 1) begin : g_arb
    logic                locked_s;
    logic [REQ_SELW-1:0] lock_idx_s;

    vx_dcache_arb_rr #(
      .NUM_REQS (NUM_REQS),
      .SELW     (REQ_SELW)
    ) u_rr (
      .clk          (clk),
      .reset        (reset),
      .pending      (pending_s),
      .done         (done_s),
      .grant_valid  (grant_valid_s),
      .grant_idx    (grant_idx_s),
      .grant_onehot (grant_onehot_s),
      .locked       (locked_s),
      .lock_idx     (lock_idx_s)
    );

    vx_dcache_arb_chk #(
      .NUM_REQS (NUM_REQS),
      .SELW     (REQ_SELW)
    ) u_chk (
      .clk       (clk),
      .reset     (reset),
      .locked    (locked_s),
      .lock_idx  (lock_idx_s),
      .pending   (pending_s),
      .rsp_valid (out_rsp_valid),
      .rsp_idx   (rsp_idx_s)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_tag
      assign req_tag_s[i] = {in_req_tag[grant_idx_s][i], grant_idx_s};
    end
    assign rsp_idx_s = out_rsp_tag[REQ_SELW-1:0];
    assign rsp_tag_s = out_rsp_tag[TAG_OUT_WIDTH-1:REQ_SELW];
  end else begin : g_pass
    assign grant_valid_s  = pending_s[0];
    assign grant_idx_s    = '0;
    assign grant_onehot_s = pending_s;
    for (genvar i = 0; i < LANES; i++) begin : g_tag
      assign req_tag_s[i] = in_req_tag[0][i];
    end
    assign rsp_idx_s = '0;
    assign rsp_tag_s = out_rsp_tag;
  end

  // Steer the granted requester onto the D$ port and responses back by index.
  always_comb begin
    out_req_valid  = '0;
    out_req_rw     = '0;
    out_req_addr   = '0;
    out_req_byteen = '0;
    out_req_data   = '0;
    out_req_tag    = '0;
    in_req_ready   = '0;
    out_rsp_ready  = 1'b0;
    in_rsp_valid   = '0;
    in_rsp_tmask   = '0;
    in_rsp_data    = '0;
    in_rsp_tag     = '0;
    if (reset) begin
      out_rsp_ready = 1'b0;
    end else begin
      out_req_valid  = grant_valid_s ? in_req_valid[grant_idx_s] : '0;
      out_req_rw     = in_req_rw[grant_idx_s];
      out_req_addr   = in_req_addr[grant_idx_s];
      out_req_byteen = in_req_byteen[grant_idx_s];
      out_req_data   = in_req_data[grant_idx_s];
      out_req_tag    = req_tag_s;
      for (int r = 0; r < NUM_REQS; r++) begin
        in_req_ready[r] = grant_onehot_s[r] ? out_req_ready : '0;
        in_rsp_valid[r] = out_rsp_valid && rsp_ok_s && (rsp_idx_s == REQ_SELW'(r));
        in_rsp_tmask[r] = out_rsp_tmask;
        in_rsp_data[r]  = out_rsp_data;
        in_rsp_tag[r]   = rsp_tag_s;
      end
      // Out-of-range index: swallow the response rather than stall the cache.
      out_rsp_ready = rsp_ok_s ? rsp_ready_pad_s[rsp_idx_s] : 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_dcache_arb.sv
// Scoreboard bench for vx_dcache_arb (2 requesters, 4 lanes, 8-bit tags):
// expected port values are queued with each stimulus cycle, compared mid-cycle.
module tb_vx_dcache_arb;

  localparam int NR = 2;
  localparam int LN = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int TOW = 9;

  logic clk;
  logic reset;
  logic [NR-1:0][LN-1:0]          in_req_valid, in_req_rw, in_req_ready;
  logic [NR-1:0][LN-1:0][AW-1:0]  in_req_addr;
  logic [NR-1:0][LN-1:0][DW/8-1:0] in_req_byteen;
  logic [NR-1:0][LN-1:0][DW-1:0]  in_req_data;
  logic [NR-1:0][LN-1:0][TW-1:0]  in_req_tag;
  logic [LN-1:0]                  out_req_valid, out_req_rw, out_req_ready;
  logic [LN-1:0][AW-1:0]          out_req_addr;
  logic [LN-1:0][DW/8-1:0]        out_req_byteen;
  logic [LN-1:0][DW-1:0]          out_req_data;
  logic [LN-1:0][TOW-1:0]         out_req_tag;
  logic                           out_rsp_valid, out_rsp_ready;
  logic [LN-1:0]                  out_rsp_tmask;
  logic [LN-1:0][DW-1:0]          out_rsp_data;
  logic [TOW-1:0]                 out_rsp_tag;
  logic [NR-1:0]                  in_rsp_valid, in_rsp_ready;
  logic [NR-1:0][LN-1:0]          in_rsp_tmask;
  logic [NR-1:0][LN-1:0][DW-1:0]  in_rsp_data;
  logic [NR-1:0][TW-1:0]          in_rsp_tag;

  vx_dcache_arb #(
    .NUM_REQS(NR), .LANES(LN), .ADDRW(AW), .DATAW(DW), .TAG_IN_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_byteen(in_req_byteen), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_byteen(out_req_byteen), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_tmask(out_rsp_tmask), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag), .out_rsp_ready(out_rsp_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_tmask(in_rsp_tmask), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_OVALID = 0, K_IREADY = 1, K_OTAG0 = 2, K_OADDR2 = 3, K_ODATA3 = 4,
                 K_ORSPRDY = 5, K_IRSPVAL = 6, K_IRSPTAG1 = 7, K_IRSPTMASK1 = 8,
                 K_IRSPTAG0 = 9, K_ORW = 10, K_OBYTEEN = 11, K_IRSPDATA1 = 12;

  typedef struct {
    int          kind;
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input int kind, input string name, input logic [63:0] v);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_OVALID:     obs = 64'(out_req_valid);
        K_IREADY:     obs = 64'(in_req_ready);
        K_OTAG0:      obs = 64'(out_req_tag[0]);
        K_OADDR2:     obs = 64'(out_req_addr[2]);
        K_ODATA3:     obs = 64'(out_req_data[3]);
        K_ORSPRDY:    obs = 64'(out_rsp_ready);
        K_IRSPVAL:    obs = 64'(in_rsp_valid);
        K_IRSPTAG1:   obs = 64'(in_rsp_tag[1]);
        K_IRSPTMASK1: obs = 64'(in_rsp_tmask[1]);
        K_IRSPTAG0:   obs = 64'(in_rsp_tag[0]);
        K_ORW:        obs = 64'(out_req_rw);
        K_OBYTEEN:    obs = 64'(out_req_byteen);
        K_IRSPDATA1:  obs = 64'(in_rsp_data[1][2]);
        default:      obs = '1;
      endcase
      check_eq(e.name, obs, e.exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_byteen = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    out_req_ready = '0;
    out_rsp_valid = 1'b0;
    out_rsp_tmask = '0;
    out_rsp_data  = '0;
    out_rsp_tag   = '0;
    in_rsp_ready  = '0;
  endtask

  // Requester r: addr 0x100+r*16+lane, data 0xD0000000+r*16+lane, rw = r.
  task automatic set_req(input int r, input logic [LN-1:0] valid, input logic [TW-1:0] tag);
    for (int l = 0; l < LN; l++) begin
      in_req_valid[r][l]  = valid[l];
      in_req_rw[r][l]     = (r == 1);
      in_req_addr[r][l]   = 30'h100 + AW'(r * 16 + l);
      in_req_data[r][l]   = 32'hD000_0000 + DW'(r * 16 + l);
      in_req_byteen[r][l] = 4'hF;
      in_req_tag[r][l]    = tag;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();

    // Reset: everything active on the inputs, yet nothing may show on outputs.
    set_req(0, 4'hF, 8'h12);
    set_req(1, 4'hF, 8'h34);
    out_req_ready = 4'hF;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = 9'h0AB;
    in_rsp_ready  = 2'b11;
    expect_v(K_OVALID,  "rst_oreq_valid", 64'h0);
    expect_v(K_IREADY,  "rst_ireq_ready", 64'h0);
    expect_v(K_ORSPRDY, "rst_orsp_ready", 64'h0);
    expect_v(K_IRSPVAL, "rst_irsp_valid", 64'h0);
    step();
    reset = 1'b0;

    // Fairness: both always fully valid and accepted -> 0,1,0,1.
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      set_req(0, 4'hF, 8'h12);
      set_req(1, 4'hF, 8'h34);
      out_req_ready = 4'hF;
      if (c % 2 == 0) begin
        expect_v(K_IREADY, $sformatf("fair%0d_ready", c), 64'h0F);
        expect_v(K_OTAG0,  $sformatf("fair%0d_tag", c),   64'h024);
      end else begin
        expect_v(K_IREADY, $sformatf("fair%0d_ready", c), 64'hF0);
        expect_v(K_OTAG0,  $sformatf("fair%0d_tag", c),   64'h069);
      end
      step();
    end

    // Single requester fully accepted at once; pointer moves to 1.
    clear_inputs();
    set_req(0, 4'hF, 8'h12);
    out_req_ready = 4'hF;
    expect_v(K_OVALID,  "single_valid",  64'hF);
    expect_v(K_IREADY,  "single_ready",  64'h0F);
    expect_v(K_OTAG0,   "single_tag",    64'h024);
    expect_v(K_OADDR2,  "single_addr2",  64'h102);
    expect_v(K_OBYTEEN, "single_byteen", 64'hFFFF);
    step();

    // Both pending with pointer at 1 -> requester 1 wins.
    clear_inputs();
    set_req(0, 4'hF, 8'h12);
    set_req(1, 4'hF, 8'h34);
    out_req_ready = 4'hF;
    expect_v(K_IREADY, "ptr1_ready", 64'hF0);
    expect_v(K_ODATA3, "ptr1_data3", 64'hD000_0013);
    expect_v(K_ORW,    "ptr1_rw",    64'hF);
    step();

    // Partial accept: req0 locks, finishes remaining lanes, then req1.
    clear_inputs();
    set_req(0, 4'hF, 8'h12);
    set_req(1, 4'h3, 8'h34);
    out_req_ready = 4'h5;
    expect_v(K_OVALID, "part0_valid", 64'hF);
    expect_v(K_IREADY, "part0_ready", 64'h05);
    step();
    set_req(0, 4'hA, 8'h12);
    out_req_ready = 4'hF;
    expect_v(K_OVALID, "part1_valid", 64'hA);
    expect_v(K_IREADY, "part1_ready", 64'h0F);
    step();
    set_req(0, 4'h0, 8'h12);
    expect_v(K_OVALID, "part2_valid", 64'h3);
    expect_v(K_IREADY, "part2_ready", 64'hF0);
    expect_v(K_OTAG0,  "part2_tag",   64'h069);
    step();

    // Lock to requester 1 overriding a pointer that favours requester 0.
    clear_inputs();
    set_req(1, 4'hF, 8'h34);
    out_req_ready = 4'h3;
    expect_v(K_IREADY, "lk1_ready", 64'h30);
    step();
    set_req(0, 4'hF, 8'h12);
    set_req(1, 4'hC, 8'h34);
    out_req_ready = 4'h0;
    expect_v(K_OVALID, "lk1_hold_valid", 64'hC);
    expect_v(K_OTAG0,  "lk1_hold_tag",   64'h069);
    step();

    // Reset mid-lock: outputs drop immediately, lock and pointer clear.
    reset         = 1'b1;
    out_req_ready = 4'hF;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = 9'h0AB;
    in_rsp_ready  = 2'b11;
    expect_v(K_OVALID,  "rstlk_oreq_valid", 64'h0);
    expect_v(K_IREADY,  "rstlk_ireq_ready", 64'h0);
    expect_v(K_ORSPRDY, "rstlk_orsp_ready", 64'h0);
    expect_v(K_IRSPVAL, "rstlk_irsp_valid", 64'h0);
    step();
    reset = 1'b0;
    clear_inputs();
    set_req(0, 4'hF, 8'h12);
    set_req(1, 4'hF, 8'h34);
    out_req_ready = 4'hF;
    expect_v(K_IREADY, "post_rst_ready", 64'h0F);
    expect_v(K_OTAG0,  "post_rst_tag",   64'h024);
    step();

    // Protocol violation: locked requester 1 drops every lane.
    clear_inputs();
    set_req(0, 4'hF, 8'h12);
    set_req(1, 4'hF, 8'h34);
    out_req_ready = 4'h1;
    expect_v(K_IREADY, "viol_lock_ready", 64'h10);
    step();
    set_req(1, 4'h0, 8'h34);
    out_req_ready = 4'hF;
    expect_v(K_OVALID, "viol_drop_valid", 64'h0);
    expect_v(K_IREADY, "viol_drop_ready", 64'hF0);
    step();
    expect_v(K_OVALID, "viol_next_valid", 64'hF);
    expect_v(K_IREADY, "viol_next_ready", 64'h0F);
    expect_v(K_OTAG0,  "viol_next_tag",   64'h024);
    step();

    // Response routing by tag LSB.
    clear_inputs();
    out_rsp_valid   = 1'b1;
    out_rsp_tag     = 9'h0AB;
    out_rsp_tmask   = 4'h6;
    out_rsp_data[2] = 32'hCAFE_0002;
    in_rsp_ready    = 2'b11;
    expect_v(K_IRSPVAL,    "rsp1_valid", 64'h2);
    expect_v(K_IRSPTAG1,   "rsp1_tag",   64'h55);
    expect_v(K_IRSPTMASK1, "rsp1_tmask", 64'h6);
    expect_v(K_IRSPDATA1,  "rsp1_data2", 64'hCAFE_0002);
    expect_v(K_ORSPRDY,    "rsp1_ready", 64'h1);
    step();
    in_rsp_ready = 2'b01;
    expect_v(K_IRSPVAL, "rsp1_stall_valid", 64'h2);
    expect_v(K_ORSPRDY, "rsp1_stall_ready", 64'h0);
    step();
    out_rsp_tag = 9'h0AA;
    expect_v(K_IRSPVAL,  "rsp0_valid", 64'h1);
    expect_v(K_IRSPTAG0, "rsp0_tag",   64'h55);
    expect_v(K_ORSPRDY,  "rsp0_ready", 64'h1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
